// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - shared opcodes, state encoding and default widths for sys_ctrl
package sys_ctrl_pkg;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_ADDR_WIDTH     = 4;
    localparam int DEF_ALU_FUNC_WIDTH = 4;

    localparam logic [7:0] OP_RF_WR    = 8'hAA;
    localparam logic [7:0] OP_RF_RD    = 8'hBB;
    localparam logic [7:0] OP_ALU_OPER = 8'hCC;
    localparam logic [7:0] OP_ALU_FUNC = 8'hDD;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ADDR  = 4'd1,
        WR_DATA  = 4'd2,
        RD_ADDR  = 4'd3,
        RD_WAIT  = 4'd4,
        OP_A     = 4'd5,
        OP_B     = 4'd6,
        ALU_FN   = 4'd7,
        ALU_WAIT = 4'd8,
        TX_B0    = 4'd9,
        TX_B1    = 4'd10
    } state_t;

endpackage

// File: rtl/sys_ctrl.sv
// rtl/sys_ctrl.sv - UART command decoder driving RegFile, ALU and TX FIFO
module sys_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int ALU_FUNC_WIDTH = DEF_ALU_FUNC_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RX_DATA,
    input  logic                      RX_DATA_VALID,
    output logic [ADDR_WIDTH-1:0]     RF_ADDR,
    output logic [DATA_WIDTH-1:0]     RF_WR_DATA,
    output logic                      RF_WR_EN,
    output logic                      RF_RD_EN,
    input  logic [DATA_WIDTH-1:0]     RF_RD_DATA,
    input  logic                      RF_RD_DATA_VALID,
    output logic [ALU_FUNC_WIDTH-1:0] ALU_FUNC,
    output logic                      ALU_EN,
    output logic                      ALU_CLK_EN,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      ALU_OUT_VALID,
    output logic [DATA_WIDTH-1:0]     FIFO_WR_DATA,
    output logic                      FIFO_WR_INC,
    input  logic                      FIFO_FULL
);

    state_t                    state, state_n;
    logic [2*DATA_WIDTH-1:0]   result, result_n;
    logic                      tx_two, tx_two_n;
    logic [ADDR_WIDTH-1:0]     rf_addr_n;
    logic [DATA_WIDTH-1:0]     rf_wr_data_n;
    logic                      rf_wr_en_n, rf_rd_en_n;
    logic [ALU_FUNC_WIDTH-1:0] alu_func_n;
    logic                      alu_en_n, alu_clk_en_n;
    logic [DATA_WIDTH-1:0]     fifo_wr_data_n;
    logic                      fifo_wr_inc_n;

    // State and every output are registered together so all strobes land one cycle after their trigger
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            result       <= '0;
            tx_two       <= 1'b0;
            RF_ADDR      <= '0;
            RF_WR_DATA   <= '0;
            RF_WR_EN     <= 1'b0;
            RF_RD_EN     <= 1'b0;
            ALU_FUNC     <= '0;
            ALU_EN       <= 1'b0;
            ALU_CLK_EN   <= 1'b0;
            FIFO_WR_DATA <= '0;
            FIFO_WR_INC  <= 1'b0;
        end else begin
            state        <= state_n;
            result       <= result_n;
            tx_two       <= tx_two_n;
            RF_ADDR      <= rf_addr_n;
            RF_WR_DATA   <= rf_wr_data_n;
            RF_WR_EN     <= rf_wr_en_n;
            RF_RD_EN     <= rf_rd_en_n;
            ALU_FUNC     <= alu_func_n;
            ALU_EN       <= alu_en_n;
            ALU_CLK_EN   <= alu_clk_en_n;
            FIFO_WR_DATA <= fifo_wr_data_n;
            FIFO_WR_INC  <= fifo_wr_inc_n;
        end
    end

    // Frame decode: strobes default low, data/address/enable registers hold unless a state updates them
    always_comb begin
        state_n        = state;
        result_n       = result;
        tx_two_n       = tx_two;
        rf_addr_n      = RF_ADDR;
        rf_wr_data_n   = RF_WR_DATA;
        rf_wr_en_n     = 1'b0;
        rf_rd_en_n     = 1'b0;
        alu_func_n     = ALU_FUNC;
        alu_en_n       = ALU_EN;
        alu_clk_en_n   = ALU_CLK_EN;
        fifo_wr_data_n = FIFO_WR_DATA;
        fifo_wr_inc_n  = 1'b0;
        case (state)
            IDLE: if (RX_DATA_VALID) begin
                if (RX_DATA == DATA_WIDTH'(OP_RF_WR))         state_n = WR_ADDR;
                else if (RX_DATA == DATA_WIDTH'(OP_RF_RD))    state_n = RD_ADDR;
                else if (RX_DATA == DATA_WIDTH'(OP_ALU_OPER)) state_n = OP_A;
                else if (RX_DATA == DATA_WIDTH'(OP_ALU_FUNC)) state_n = ALU_FN;
            end
            WR_ADDR: if (RX_DATA_VALID) begin
                rf_addr_n = RX_DATA[ADDR_WIDTH-1:0];
                state_n   = WR_DATA;
            end
            WR_DATA: if (RX_DATA_VALID) begin
                rf_wr_data_n = RX_DATA;
                rf_wr_en_n   = 1'b1;
                state_n      = IDLE;
            end
            RD_ADDR: if (RX_DATA_VALID) begin
                rf_addr_n  = RX_DATA[ADDR_WIDTH-1:0];
                rf_rd_en_n = 1'b1;
                state_n    = RD_WAIT;
            end
            RD_WAIT: if (RF_RD_DATA_VALID) begin
                result_n = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
                tx_two_n = 1'b0;
                state_n  = TX_B0;
            end
            OP_A: if (RX_DATA_VALID) begin
                rf_addr_n    = '0;
                rf_wr_data_n = RX_DATA;
                rf_wr_en_n   = 1'b1;
                state_n      = OP_B;
            end
            OP_B: if (RX_DATA_VALID) begin
                rf_addr_n    = ADDR_WIDTH'(1);
                rf_wr_data_n = RX_DATA;
                rf_wr_en_n   = 1'b1;
                state_n      = ALU_FN;
            end
            ALU_FN: if (RX_DATA_VALID) begin
                alu_func_n   = RX_DATA[ALU_FUNC_WIDTH-1:0];
                alu_en_n     = 1'b1;
                alu_clk_en_n = 1'b1;
                state_n      = ALU_WAIT;
            end
            ALU_WAIT: if (ALU_OUT_VALID) begin
                result_n     = ALU_OUT;
                tx_two_n     = 1'b1;
                alu_en_n     = 1'b0;
                alu_clk_en_n = 1'b0;
                state_n      = TX_B0;
            end
            TX_B0: if (!FIFO_FULL) begin
                fifo_wr_data_n = result[DATA_WIDTH-1:0];
                fifo_wr_inc_n  = 1'b1;
                state_n        = tx_two ? TX_B1 : IDLE;
            end
            TX_B1: if (!FIFO_FULL) begin
                fifo_wr_data_n = result[2*DATA_WIDTH-1:DATA_WIDTH];
                fifo_wr_inc_n  = 1'b1;
                state_n        = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// tb/tb_sys_ctrl.sv - scoreboard bench for sys_ctrl command decoding
module tb_sys_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_DATA = '0;
    logic        RX_DATA_VALID = 1'b0;
    logic [3:0]  RF_ADDR;
    logic [7:0]  RF_WR_DATA;
    logic        RF_WR_EN, RF_RD_EN;
    logic [7:0]  RF_RD_DATA = '0;
    logic        RF_RD_DATA_VALID = 1'b0;
    logic [3:0]  ALU_FUNC;
    logic        ALU_EN, ALU_CLK_EN;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VALID = 1'b0;
    logic [7:0]  FIFO_WR_DATA;
    logic        FIFO_WR_INC;
    logic        FIFO_FULL = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0, rd_cnt = 0, push_cnt = 0;
    logic full_seen = 1'b0;

    logic [11:0] exp_wr[$];
    logic [3:0]  exp_rd[$];
    logic [7:0]  exp_push[$];

    sys_ctrl dut (
        .CLK(CLK), .RST(RST),
        .RX_DATA(RX_DATA), .RX_DATA_VALID(RX_DATA_VALID),
        .RF_ADDR(RF_ADDR), .RF_WR_DATA(RF_WR_DATA),
        .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
        .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VALID(RF_RD_DATA_VALID),
        .ALU_FUNC(ALU_FUNC), .ALU_EN(ALU_EN), .ALU_CLK_EN(ALU_CLK_EN),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
        .FIFO_WR_DATA(FIFO_WR_DATA), .FIFO_WR_INC(FIFO_WR_INC),
        .FIFO_FULL(FIFO_FULL)
    );

    always #5 CLK = ~CLK;

    // Output monitor: pops scoreboard entries on every strobe, sampled mid-cycle
    always @(negedge CLK) begin
        if (RST) begin
            if (RF_WR_EN && RF_RD_EN) begin
                miscompares++;
                $display("FAIL strobe_overlap wr=%b rd=%b required not both", RF_WR_EN, RF_RD_EN);
            end
            if (RF_WR_EN) begin
                vectors++; wr_cnt++;
                if (exp_wr.size() == 0) begin
                    miscompares++;
                    $display("FAIL rf_write got addr=%h data=%h required none", RF_ADDR, RF_WR_DATA);
                end else begin
                    logic [11:0] e;
                    e = exp_wr.pop_front();
                    if ({RF_ADDR, RF_WR_DATA} !== e) begin
                        miscompares++;
                        $display("FAIL rf_write got %h required %h", {RF_ADDR, RF_WR_DATA}, e);
                    end
                end
            end
            if (RF_RD_EN) begin
                vectors++; rd_cnt++;
                if (exp_rd.size() == 0) begin
                    miscompares++;
                    $display("FAIL rf_read got addr=%h required none", RF_ADDR);
                end else begin
                    logic [3:0] e;
                    e = exp_rd.pop_front();
                    if (RF_ADDR !== e) begin
                        miscompares++;
                        $display("FAIL rf_read got addr=%h required %h", RF_ADDR, e);
                    end
                end
            end
            if (FIFO_WR_INC) begin
                vectors++; push_cnt++;
                if (full_seen) begin
                    miscompares++;
                    $display("FAIL push_while_full got push=1 required 0");
                end
                if (exp_push.size() == 0) begin
                    miscompares++;
                    $display("FAIL fifo_push got %h required none", FIFO_WR_DATA);
                end else begin
                    logic [7:0] e;
                    e = exp_push.pop_front();
                    if (FIFO_WR_DATA !== e) begin
                        miscompares++;
                        $display("FAIL fifo_push got %h required %h", FIFO_WR_DATA, e);
                    end
                end
            end
        end
        full_seen = FIFO_FULL;
    end

    task automatic send_frame(input logic [7:0] b);
        @(posedge CLK); #1;
        RX_DATA = b; RX_DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        RX_DATA_VALID = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        idle_cycles(2);
        vectors++;
        if ({RF_ADDR, RF_WR_DATA, RF_WR_EN, RF_RD_EN, ALU_FUNC, ALU_EN, ALU_CLK_EN,
             FIFO_WR_DATA, FIFO_WR_INC} !== 30'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got nonzero required all 0");
        end
        RST = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_rf_write();
        int w0, p0;
        w0 = wr_cnt; p0 = push_cnt;
        exp_wr.push_back({4'd3, 8'h5A});
        send_frame(8'hAA); send_frame(8'h03); send_frame(8'h5A);
        idle_cycles(4);
        vectors++;
        if (wr_cnt - w0 !== 1 || push_cnt - p0 !== 0) begin
            miscompares++;
            $display("FAIL rf_write_count got wr=%0d push=%0d required wr=1 push=0", wr_cnt - w0, push_cnt - p0);
        end
    endtask

    task automatic test_rf_read(input logic [3:0] a, input logic [7:0] d);
        int r0, p0, t;
        r0 = rd_cnt; p0 = push_cnt;
        exp_rd.push_back(a);
        exp_push.push_back(d);
        send_frame(8'hBB); send_frame({4'h0, a});
        t = 0;
        while (!RF_RD_EN && t < 20) begin @(posedge CLK); #1; t++; end
        vectors++;
        if (!RF_RD_EN) begin
            miscompares++;
            $display("FAIL rd_en_timeout got 0 required 1");
        end
        idle_cycles(2);
        RF_RD_DATA = d; RF_RD_DATA_VALID = 1'b1;
        idle_cycles(1);
        RF_RD_DATA_VALID = 1'b0;
        idle_cycles(5);
        vectors++;
        if (rd_cnt - r0 !== 1 || push_cnt - p0 !== 1) begin
            miscompares++;
            $display("FAIL rf_read_count got rd=%0d push=%0d required rd=1 push=1", rd_cnt - r0, push_cnt - p0);
        end
    endtask

    task automatic test_alu(input logic with_ops, input logic [7:0] fn, input logic [15:0] res,
                            input int full_cycles);
        int p0, t;
        p0 = push_cnt;
        if (with_ops) begin
            exp_wr.push_back({4'd0, 8'h10});
            exp_wr.push_back({4'd1, 8'h20});
            send_frame(8'hCC); send_frame(8'h10); send_frame(8'h20);
        end else begin
            send_frame(8'hDD);
        end
        exp_push.push_back(res[7:0]);
        exp_push.push_back(res[15:8]);
        send_frame(fn);
        t = 0;
        while (!ALU_EN && t < 20) begin @(posedge CLK); #1; t++; end
        vectors++;
        if (ALU_EN !== 1'b1 || ALU_CLK_EN !== 1'b1 || ALU_FUNC !== fn[3:0]) begin
            miscompares++;
            $display("FAIL alu_start got en=%b clk_en=%b func=%h required 1 1 %h", ALU_EN, ALU_CLK_EN, ALU_FUNC, fn[3:0]);
        end
        if (full_cycles > 0) FIFO_FULL = 1'b1;
        idle_cycles(3);
        vectors++;
        if (ALU_EN !== 1'b1 || ALU_CLK_EN !== 1'b1) begin
            miscompares++;
            $display("FAIL alu_hold got en=%b clk_en=%b required 1 1", ALU_EN, ALU_CLK_EN);
        end
        ALU_OUT = res; ALU_OUT_VALID = 1'b1;
        idle_cycles(1);
        ALU_OUT_VALID = 1'b0;
        vectors++;
        if (ALU_EN !== 1'b0 || ALU_CLK_EN !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_release got en=%b clk_en=%b required 0 0", ALU_EN, ALU_CLK_EN);
        end
        if (full_cycles > 0) begin
            idle_cycles(full_cycles);
            vectors++;
            if (push_cnt - p0 !== 0) begin
                miscompares++;
                $display("FAIL full_hold got pushes=%0d required 0", push_cnt - p0);
            end
            FIFO_FULL = 1'b0;
        end
        idle_cycles(6);
        vectors++;
        if (push_cnt - p0 !== 2) begin
            miscompares++;
            $display("FAIL alu_push_count got %0d required 2", push_cnt - p0);
        end
    endtask

    task automatic test_reset_mid_command();
        int w0;
        w0 = wr_cnt;
        send_frame(8'h55);
        send_frame(8'hAA); send_frame(8'h01);
        idle_cycles(1);
        #2 RST = 1'b0;
        #1;
        vectors++;
        if ({RF_ADDR, RF_WR_DATA, RF_WR_EN, RF_RD_EN, ALU_FUNC, ALU_EN, ALU_CLK_EN,
             FIFO_WR_DATA, FIFO_WR_INC} !== 30'd0) begin
            miscompares++;
            $display("FAIL async_reset got nonzero required all 0");
        end
        idle_cycles(2);
        RST = 1'b1;
        idle_cycles(1);
        vectors++;
        if (wr_cnt - w0 !== 0) begin
            miscompares++;
            $display("FAIL reset_discard got wr=%0d required 0", wr_cnt - w0);
        end
        test_rf_read(4'd1, 8'hC3);
    endtask

    task automatic test_back_to_back();
        int r0, p0, w0, t;
        r0 = rd_cnt; p0 = push_cnt; w0 = wr_cnt;
        exp_rd.push_back(4'd7);
        exp_push.push_back(8'hE1);
        exp_wr.push_back({4'd5, 8'h99});
        send_frame(8'hBB); send_frame(8'h07);
        send_frame(8'hAA);
        t = 0;
        while (t < 2) begin @(posedge CLK); #1; t++; end
        RF_RD_DATA = 8'hE1; RF_RD_DATA_VALID = 1'b1;
        idle_cycles(1);
        RF_RD_DATA_VALID = 1'b0;
        send_frame(8'hAA); send_frame(8'h05); send_frame(8'h99);
        idle_cycles(4);
        vectors++;
        if (rd_cnt - r0 !== 1 || push_cnt - p0 !== 1 || wr_cnt - w0 !== 1) begin
            miscompares++;
            $display("FAIL back_to_back got rd=%0d push=%0d wr=%0d required 1 1 1", rd_cnt - r0, push_cnt - p0, wr_cnt - w0);
        end
    endtask

    initial begin
        test_reset();
        test_rf_write();
        test_rf_read(4'd2, 8'h77);
        test_alu(1'b1, 8'h00, 16'h0030, 0);
        test_alu(1'b0, 8'h02, 16'h1234, 5);
        test_reset_mid_command();
        test_back_to_back();
        vectors++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0 || exp_push.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got wr=%0d rd=%0d push=%0d required 0 0 0",
                     exp_wr.size(), exp_rd.size(), exp_push.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
